// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory completer.
package apb_mem_pkg;

    localparam int unsigned WCNT_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    function automatic logic in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

    function automatic int unsigned wrap_addr(input int unsigned addr, input int unsigned depth);
        return addr % depth;
    endfunction

endpackage

// File: rtl/apb_mem_if.sv
// APB bus bundle between the master and the memory completer.
interface apb_mem_if #(
    parameter int unsigned ADDR_width = 4,
    parameter int unsigned DATA_width = 8
);

    logic                  P_sel;
    logic                  P_enable;
    logic                  P_write;
    logic [ADDR_width-1:0] P_addr;
    logic [DATA_width-1:0] P_wdata;
    logic [DATA_width-1:0] P_rdata;
    logic                  P_ready;
    logic                  P_slverr;

    modport master (
        output P_sel, P_enable, P_write, P_addr, P_wdata,
        input  P_rdata, P_ready, P_slverr
    );

    modport slave (
        input  P_sel, P_enable, P_write, P_addr, P_wdata,
        output P_rdata, P_ready, P_slverr
    );

endinterface

// File: rtl/apb_mem_array.sv
// Register-file storage: async clear, one write port, one combinational read port.
module apb_mem_array
    import apb_mem_pkg::*;
#(
    parameter int unsigned DATA_width = 8,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_width-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_width-1:0] rdata_o
);

    logic [DATA_width-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer backed by a register-file memory with programmable wait states.
// Define APB_MEM_SLVERR_EN to flag out-of-range accesses with P_slverr instead of aliasing.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int unsigned ADDR_width  = 4,
    parameter int unsigned DATA_width  = 8,
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic     P_clk,
    input  logic     P_reset,
    apb_mem_if.slave bus
);

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_e                state_q, state_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [ADDR_width-1:0] addr_q;
    logic                  write_q;
    logic [DATA_width-1:0] wdata_q;
    logic [DATA_width-1:0] rdata_q, rdata_d;

    logic                  setup, access, load;
    logic                  ready, slverr, mem_we;
    logic [IDX_W-1:0]      ridx, widx;
    logic [DATA_width-1:0] mem_rdata;

    assign setup  = bus.P_sel & ~bus.P_enable;
    assign access = bus.P_sel & bus.P_enable;
    // Completion needs P_enable=1, so a setup phase can only be accepted from IDLE.
    assign load   = (state_q == ST_IDLE) & setup;

    assign ridx = IDX_W'(wrap_addr(32'(bus.P_addr), MEM_DEPTH));
    assign widx = IDX_W'(wrap_addr(32'(addr_q), MEM_DEPTH));

`ifdef APB_MEM_SLVERR_EN
    logic setup_ok, addr_ok;
    assign setup_ok = in_range(32'(bus.P_addr), MEM_DEPTH);
    assign addr_ok  = in_range(32'(addr_q), MEM_DEPTH);
`endif

    always_ff @(posedge P_clk or posedge P_reset) begin
        if (P_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (setup) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!bus.P_sel) state_d = ST_IDLE;
                else if (access && wcnt_q == '0) state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        slverr = 1'b0;
        mem_we = 1'b0;
        if (state_q == ST_ACCESS && access && wcnt_q == '0) ready = 1'b1;
`ifdef APB_MEM_SLVERR_EN
        slverr = ready & ~addr_ok;
        mem_we = ready & write_q & addr_ok;
`else
        mem_we = ready & write_q;
`endif
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (load) begin
            wcnt_d = WCNT_W'(WAIT_STATES);
        end else if (state_q == ST_ACCESS && access && wcnt_q != '0) begin
            wcnt_d = wcnt_q - WCNT_W'(1);
        end
`ifdef APB_MEM_SLVERR_EN
        rdata_d = setup_ok ? mem_rdata : '0;
`else
        rdata_d = mem_rdata;
`endif
    end

    always_ff @(posedge P_clk or posedge P_reset) begin
        if (P_reset) begin
            wcnt_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            if (load) begin
                addr_q  <= bus.P_addr;
                write_q <= bus.P_write;
                wdata_q <= bus.P_wdata;
                rdata_q <= rdata_d;
            end
        end
    end

    apb_mem_array #(
        .DATA_width (DATA_width),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk_i   (P_clk),
        .rst_i   (P_reset),
        .we_i    (mem_we),
        .waddr_i (widx),
        .wdata_i (wdata_q),
        .raddr_i (ridx),
        .rdata_o (mem_rdata)
    );

    assign bus.P_ready  = ready;
    assign bus.P_slverr = slverr;
    assign bus.P_rdata  = rdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: three instances (0, 2, 3 wait states; depth 16/12/16).
module tb_apb_mem_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sel = '0;
    logic       en = 1'b0;
    logic       wr = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] wdata = '0;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

`ifdef APB_MEM_SLVERR_EN
    localparam bit SLVERR = 1'b1;
`else
    localparam bit SLVERR = 1'b0;
`endif

    apb_mem_if #(.ADDR_width(4), .DATA_width(8)) b0 ();
    apb_mem_if #(.ADDR_width(4), .DATA_width(8)) b1 ();
    apb_mem_if #(.ADDR_width(4), .DATA_width(8)) b2 ();

    assign b0.P_sel = sel[0];
    assign b1.P_sel = sel[1];
    assign b2.P_sel = sel[2];
    assign b0.P_enable = en;
    assign b1.P_enable = en;
    assign b2.P_enable = en;
    assign b0.P_write = wr;
    assign b1.P_write = wr;
    assign b2.P_write = wr;
    assign b0.P_addr = addr;
    assign b1.P_addr = addr;
    assign b2.P_addr = addr;
    assign b0.P_wdata = wdata;
    assign b1.P_wdata = wdata;
    assign b2.P_wdata = wdata;

    logic       rdy_m [3];
    logic       err_m [3];
    logic [7:0] rd_m  [3];
    assign rdy_m[0] = b0.P_ready;
    assign rdy_m[1] = b1.P_ready;
    assign rdy_m[2] = b2.P_ready;
    assign err_m[0] = b0.P_slverr;
    assign err_m[1] = b1.P_slverr;
    assign err_m[2] = b2.P_slverr;
    assign rd_m[0]  = b0.P_rdata;
    assign rd_m[1]  = b1.P_rdata;
    assign rd_m[2]  = b2.P_rdata;

    apb_mem_slave #(.ADDR_width(4), .DATA_width(8), .MEM_DEPTH(16), .WAIT_STATES(0))
        u_ws0 (.P_clk(clk), .P_reset(rst), .bus(b0));
    apb_mem_slave #(.ADDR_width(4), .DATA_width(8), .MEM_DEPTH(12), .WAIT_STATES(2))
        u_ws2 (.P_clk(clk), .P_reset(rst), .bus(b1));
    apb_mem_slave #(.ADDR_width(4), .DATA_width(8), .MEM_DEPTH(16), .WAIT_STATES(3))
        u_ws3 (.P_clk(clk), .P_reset(rst), .bus(b2));

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Enters and leaves #1 after a rising edge; bus is left idle-ready for a back-to-back call.
    task automatic xfer(input int d, input logic w, input logic [3:0] a, input logic [7:0] wd,
                        input logic [7:0] erd, input logic eerr, input int ecyc);
        exp_t e;
        int   cyc;
        bit   done;
        e.rd = erd;
        e.err = eerr;
        e.cyc = ecyc;
        sb.push_back(e);
        sel = '0;
        sel[d] = 1'b1;
        en = 1'b0;
        wr = w;
        addr = a;
        wdata = wd;
        @(posedge clk); #1;
        en = 1'b1;
        cyc = 1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            cyc++;
            if (rdy_m[d]) begin
                e = sb.pop_front();
                if (!w) check("rdata", 32'(rd_m[d]), 32'(e.rd));
                check("slverr", 32'(err_m[d]), 32'(e.err));
                check("cycles", cyc, e.cyc);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        check("completed", 32'(done), 32'd1);
        if (!done) void'(sb.pop_front());
        en = 1'b0;
        sel = '0;
    endtask

    initial begin
        int t0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 32'(rdy_m[d]), 32'd0);
            check("rst_rdata", 32'(rd_m[d]), 32'd0);
            check("rst_slverr", 32'(err_m[d]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // zero wait states, single then back-to-back transfers
        xfer(0, 1'b1, 4'hA, 8'h55, 8'h00, 1'b0, 2);
        xfer(0, 1'b0, 4'hA, 8'h00, 8'h55, 1'b0, 2);
        t0 = cyc_cnt;
        xfer(0, 1'b1, 4'hA, 8'h55, 8'h00, 1'b0, 2);
        xfer(0, 1'b1, 4'hB, 8'h56, 8'h00, 1'b0, 2);
        xfer(0, 1'b0, 4'hB, 8'h00, 8'h56, 1'b0, 2);
        xfer(0, 1'b0, 4'hA, 8'h00, 8'h55, 1'b0, 2);
        check("b2b_cycles", cyc_cnt - t0, 8);

        // two wait states, depth 12: latency and out-of-range handling
        xfer(1, 1'b1, 4'hA, 8'h55, 8'h00, 1'b0, 4);
        xfer(1, 1'b0, 4'hA, 8'h00, 8'h55, 1'b0, 4);
        xfer(1, 1'b1, 4'hC, 8'h77, 8'h00, SLVERR, 4);
        xfer(1, 1'b0, 4'hC, 8'h00, SLVERR ? 8'h00 : 8'h77, SLVERR, 4);
        xfer(1, 1'b0, 4'h0, 8'h00, SLVERR ? 8'h00 : 8'h77, 1'b0, 4);
        xfer(1, 1'b0, 4'hA, 8'h00, 8'h55, 1'b0, 4);

        // abort by dropping P_sel, then P_enable without a setup phase
        sel = 3'b100; en = 1'b0; wr = 1'b1; addr = 4'h5; wdata = 8'hAA;
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        check("abort_wait", 32'(rdy_m[2]), 32'd0);
        @(posedge clk); #1;
        sel = '0; en = 1'b0;
        @(negedge clk);
        check("abort_drop", 32'(rdy_m[2]), 32'd0);
        @(posedge clk); #1;
        sel = 3'b100; en = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("no_setup", 32'(rdy_m[2]), 32'd0);
        end
        @(posedge clk); #1;
        sel = '0; en = 1'b0;
        xfer(2, 1'b0, 4'h5, 8'h00, 8'h00, 1'b0, 5);

        // reset during the second wait cycle of a write
        xfer(2, 1'b1, 4'h3, 8'h3C, 8'h00, 1'b0, 5);
        sel = 3'b100; en = 1'b0; wr = 1'b1; addr = 4'h3; wdata = 8'h99;
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        check("pre_rst_rdata", 32'(rd_m[2]), 32'h3C);
        @(posedge clk); #1;
        @(negedge clk);
        check("wait2_ready", 32'(rdy_m[2]), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(rdy_m[2]), 32'd0);
        check("mid_rst_rdata", 32'(rd_m[2]), 32'd0);
        check("mid_rst_slverr", 32'(err_m[2]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sel = '0; en = 1'b0;
        @(posedge clk); #1;
        xfer(2, 1'b0, 4'h3, 8'h00, 8'h00, 1'b0, 5);
        xfer(0, 1'b0, 4'hA, 8'h00, 8'h00, 1'b0, 2);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
